// File: rtl/key_repeat_ctrl_pkg.sv
// Shared input-path definitions for the DE2 Tetris front end: key indices,
// default debounce/auto-repeat timing and the repeat state encoding.
package input_pkg;

  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_ROT   = 1;
  localparam int KEY_DOWN  = 0;

  localparam int DB_DEFAULT  = 4;
  localparam int DAS_DEFAULT = 170;
  localparam int ARR_DEFAULT = 50;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_repeat_ctrl_if.sv
// Key bundle between the raw buttons and the game logic; the release strobe
// is named "released" because "release" is a reserved word.
interface key_repeat_ctrl_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] released;
  logic [N_KEYS-1:0] evt;

  modport master (output key_n, input level, press, released, evt);
  modport slave  (input key_n, output level, press, released, evt);
endinterface

// File: rtl/key_repeat_ctrl_chan.sv
// One key channel: two-FF synchroniser, run-length debounce and an optional
// auto-repeat engine producing press/release/action strobes.
module key_chan
  import input_pkg::*;
#(
  parameter int DB_CYCLES = DB_DEFAULT,
  parameter int RPT_DELAY = DAS_DEFAULT,
  parameter int RPT_RATE  = ARR_DEFAULT,
  parameter bit rpt_en    = 1'b1
) (
  input  logic clk1k,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic released,
  output logic evt
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TW = $clog2(max_int(RPT_DELAY, RPT_RATE));
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(RPT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(RPT_RATE - 1);

  logic          s0, s1;
  logic [CW-1:0] db_cnt;
  logic [TW-1:0] timer;
  rpt_state_t    state;
  logic          flip, rise, fall;

  // The DB_CYCLES-th consecutive differing sample flips the stable level.
  assign flip = (s1 != level) && (db_cnt == DB_LAST);
  assign rise = flip && !level;
  assign fall = flip && level;

  always_ff @(posedge clk1k) begin
    if (rst) begin
      s0       <= 1'b0;
      s1       <= 1'b0;
      db_cnt   <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
      evt      <= 1'b0;
      timer    <= '0;
      state    <= IDLE;
    end else begin
      s0       <= ~key_n;
      s1       <= s0;
      press    <= rise;
      released <= fall;
      evt      <= rise;

      if (s1 == level) begin
        db_cnt <= '0;
      end else if (flip) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // A release cancels any pending repeat, even one due this very cycle.
      if (!rpt_en || fall) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (rise) state <= DELAY;
          end
          DELAY: begin
            if (timer == DELAY_LAST) begin
              evt   <= 1'b1;
              state <= REPEAT;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          REPEAT: begin
            if (timer == RATE_LAST) begin
              evt   <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_repeat_ctrl.sv
// Multi-key front end: one independent key_chan per button, auto-repeat
// enabled per key through RPT_MASK.
module key_repeat_ctrl
  import input_pkg::*;
#(
  parameter int              N_KEYS    = 4,
  parameter int              DB_CYCLES = DB_DEFAULT,
  parameter int              RPT_DELAY = DAS_DEFAULT,
  parameter int              RPT_RATE  = ARR_DEFAULT,
  parameter logic [N_KEYS-1:0] RPT_MASK = 4'b1110
) (
  input  logic               clk1k,
  input  logic               rst,
  key_repeat_ctrl_if.slave   bus
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_RATE  (RPT_RATE),
      .rpt_en    (RPT_MASK[i])
    ) u_chan (
      .clk1k    (clk1k),
      .rst      (rst),
      .key_n    (bus.key_n[i]),
      .level    (bus.level[i]),
      .press    (bus.press[i]),
      .released (bus.released[i]),
      .evt      (bus.evt[i])
    );
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Scoreboard bench for key_repeat_ctrl: directed scenarios then random key
// activity, compared cycle by cycle against a run-length/age reference model.
`timescale 1ns/1ps
module tb_key_repeat_ctrl;

  localparam int NK  = 4;
  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int RT  = 3;
  localparam logic [NK-1:0] MASK = 4'b1110;

  logic clk;
  logic rst;
  key_repeat_ctrl_if #(.N_KEYS(NK)) bus ();

  key_repeat_ctrl #(
    .N_KEYS    (NK),
    .DB_CYCLES (DB),
    .RPT_DELAY (DLY),
    .RPT_RATE  (RT),
    .RPT_MASK  (MASK)
  ) dut (
    .clk1k (clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  logic [4*NK-1:0] exp_q[$];

  // Reference model: synchroniser as a two-deep delay, debounce as a run
  // length of differing samples, repeat as arithmetic on hold age.
  logic d0[NK], d1[NK], lvl[NK];
  int   run[NK], age[NK];
  logic [NK-1:0] kn_cur;

  task automatic modelStep(input logic [NK-1:0] kn, input logic r,
                           output logic [4*NK-1:0] exp_v);
    logic [NK-1:0] el, ep, er, ee;
    logic seen;
    el = '0; ep = '0; er = '0; ee = '0;
    for (int k = 0; k < NK; k++) begin
      if (r) begin
        d0[k] = 1'b0; d1[k] = 1'b0; lvl[k] = 1'b0; run[k] = 0; age[k] = 0;
      end else begin
        seen  = d1[k];
        d1[k] = d0[k];
        d0[k] = ~kn[k];
        if (seen == lvl[k]) begin
          run[k] = 0;
          if (lvl[k]) age[k]++;
        end else begin
          run[k]++;
          if (run[k] == DB) begin
            run[k] = 0;
            lvl[k] = ~lvl[k];
            if (lvl[k]) begin ep[k] = 1'b1; age[k] = 0; end
            else er[k] = 1'b1;
          end else if (lvl[k]) begin
            age[k]++;
          end
        end
        el[k] = lvl[k];
        ee[k] = ep[k] || (MASK[k] && lvl[k] && !ep[k] && age[k] >= DLY
                          && ((age[k] - DLY) % RT) == 0);
      end
    end
    exp_v = {el, ep, er, ee};
  endtask

  // Drive one cycle of inputs (from a negedge) and queue the expected result.
  task automatic applyStimulus(input logic [NK-1:0] kn, input logic r);
    logic [4*NK-1:0] e;
    bus.key_n = kn;
    rst       = r;
    modelStep(kn, r, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic holdFor(input int n, input logic r);
    for (int c = 0; c < n; c++) applyStimulus(kn_cur, r);
  endtask

  task automatic checkOutput(input logic [4*NK-1:0] exp_v);
    logic [4*NK-1:0] act;
    act = {bus.level, bus.press, bus.released, bus.evt};
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL outputs t=%0t level/press/release/evt got=%h/%h/%h/%h want=%h/%h/%h/%h",
               $time, act[15:12], act[11:8], act[7:4], act[3:0],
               exp_v[15:12], exp_v[11:8], exp_v[7:4], exp_v[3:0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  logic [NK-1:0] tgt;

  initial begin
    kn_cur = '1;
    bus.key_n = '1;
    rst = 1'b1;
    for (int k = 0; k < NK; k++) begin
      d0[k] = 0; d1[k] = 0; lvl[k] = 0; run[k] = 0; age[k] = 0;
    end
    holdFor(3, 1'b1);
    holdFor(3, 1'b0);

    // Clean press of key 1.
    kn_cur[1] = 1'b0; holdFor(20, 1'b0);
    kn_cur[1] = 1'b1; holdFor(10, 1'b0);

    // Bounce on key 2, then a real hold.
    kn_cur[2] = 1'b0; holdFor(3, 1'b0);
    kn_cur[2] = 1'b1; holdFor(1, 1'b0);
    kn_cur[2] = 1'b0; holdFor(3, 1'b0);
    kn_cur[2] = 1'b1; holdFor(1, 1'b0);
    kn_cur[2] = 1'b0; holdFor(20, 1'b0);
    kn_cur[2] = 1'b1; holdFor(10, 1'b0);

    // Long hold on key 3, then on non-repeating key 0.
    kn_cur[3] = 1'b0; holdFor(35, 1'b0);
    kn_cur[3] = 1'b1; holdFor(10, 1'b0);
    kn_cur[0] = 1'b0; holdFor(35, 1'b0);
    kn_cur[0] = 1'b1; holdFor(10, 1'b0);

    // Keys 3 and 2 together, key 2 released early.
    kn_cur[3] = 1'b0; kn_cur[2] = 1'b0; holdFor(20, 1'b0);
    kn_cur[2] = 1'b1; holdFor(20, 1'b0);
    kn_cur[3] = 1'b1; holdFor(10, 1'b0);

    // Reset in the middle of key 1's repeat train, key still held.
    kn_cur[1] = 1'b0; holdFor(20, 1'b0);
    holdFor(2, 1'b1);
    holdFor(30, 1'b0);
    kn_cur[1] = 1'b1; holdFor(10, 1'b0);

    // Random activity with bounces and occasional resets.
    tgt = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(39) == 0) tgt[k] = ~tgt[k];
        kn_cur[k] = ($urandom_range(11) == 0) ? tgt[k] : ~tgt[k];
      end
      applyStimulus(kn_cur, ($urandom_range(599) == 0));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
